// File: rtl/jt12_pkg.sv
// Shared jt12 definitions: busy-time default and ADPCM-A channel count.
// Also holds the vector type used for the per-channel ADPCM-A signals.
package jt12_pkg;

  localparam int JT12_BUSY_CYCLES = 32;
  localparam int JT12_ADPCMA_CH   = 6;

  typedef logic [JT12_ADPCMA_CH-1:0] adpcma_vec_t;

endpackage

// File: rtl/jt12_busy.sv
// Write-busy down-counter: load sets BUSY_CYCLES, cen paces the count to zero.
// The busy output is registered and reflects a nonzero count.
module jt12_busy
  import jt12_pkg::*;
#(
  parameter int BUSY_CYCLES = JT12_BUSY_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic cen,
  input  logic load,
  output logic busy
);

  logic [7:0] cnt_q, cnt_d;
  logic       busy_q;

  // Load wins over a decrement in the same cycle and ignores cen.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = 8'(BUSY_CYCLES);
    end else if (cen && (cnt_q != 8'd0)) begin
      cnt_d = cnt_q - 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= 8'd0;
      busy_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= (cnt_d != 8'd0);
    end
  end

  assign busy = busy_q;

endmodule

// File: rtl/jt12_status.sv
// Status register: write-busy flag, timer and ADPCM end flags, and irq_n.
// Outputs feed the status readback mux directly.
module jt12_status
  import jt12_pkg::*;
#(
  parameter int BUSY_CYCLES = JT12_BUSY_CYCLES,
  parameter int use_adpcm   = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cen,
  input  logic                      write,
  input  logic                      addr0,
  input  logic                      timer_ovf_A,
  input  logic                      timer_ovf_B,
  input  logic                      flag_en_A,
  input  logic                      flag_en_B,
  input  logic                      clr_flag_A,
  input  logic                      clr_flag_B,
  input  logic [JT12_ADPCMA_CH-1:0] adpcma_end,
  input  logic                      adpcmb_end,
  input  logic [JT12_ADPCMA_CH-1:0] adpcma_mask,
  input  logic                      adpcmb_mask,
  output logic                      busy,
  output logic                      flag_A,
  output logic                      flag_B,
  output logic [JT12_ADPCMA_CH-1:0] adpcma_flags,
  output logic                      adpcmb_flag,
  output logic                      irq_n
);

  logic        flag_a_q, flag_a_d;
  logic        flag_b_q, flag_b_d;
  adpcma_vec_t adpcma_q, adpcma_d;
  logic        adpcmb_q, adpcmb_d;
  logic        irq_n_q;

  jt12_busy #(
    .BUSY_CYCLES(BUSY_CYCLES)
  ) u_busy (
    .clk (clk),
    .rst (rst),
    .cen (cen),
    .load(write & addr0),
    .busy(busy)
  );

  // Timer flags: set beats clear so an overflow is never lost.
  always_comb begin
    flag_a_d = flag_a_q;
    flag_b_d = flag_b_q;
    if (timer_ovf_A && flag_en_A) flag_a_d = 1'b1;
    else if (clr_flag_A)          flag_a_d = 1'b0;
    if (timer_ovf_B && flag_en_B) flag_b_d = 1'b1;
    else if (clr_flag_B)          flag_b_d = 1'b0;
  end

  // ADPCM flags: the mask is a level that both clears and blocks setting.
  always_comb begin
    adpcma_d = '0;
    adpcmb_d = 1'b0;
    if (use_adpcm != 0) begin
      for (int i = 0; i < JT12_ADPCMA_CH; i++) begin
        if (adpcma_mask[i])     adpcma_d[i] = 1'b0;
        else if (adpcma_end[i]) adpcma_d[i] = 1'b1;
        else                    adpcma_d[i] = adpcma_q[i];
      end
      if (adpcmb_mask)     adpcmb_d = 1'b0;
      else if (adpcmb_end) adpcmb_d = 1'b1;
      else                 adpcmb_d = adpcmb_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flag_a_q <= 1'b0;
      flag_b_q <= 1'b0;
      adpcma_q <= '0;
      adpcmb_q <= 1'b0;
      irq_n_q  <= 1'b1;
    end else begin
      flag_a_q <= flag_a_d;
      flag_b_q <= flag_b_d;
      adpcma_q <= adpcma_d;
      adpcmb_q <= adpcmb_d;
      // Built from the flag registers, so irq_n trails the flags by one cycle.
      irq_n_q  <= ~(flag_a_q | flag_b_q | (|adpcma_q) | adpcmb_q);
    end
  end

  assign flag_A       = flag_a_q;
  assign flag_B       = flag_b_q;
  assign adpcma_flags = adpcma_q;
  assign adpcmb_flag  = adpcmb_q;
  assign irq_n        = irq_n_q;

endmodule

// File: tb/tb_jt12_status.sv
// Directed bench for jt12_status with BUSY_CYCLES=4 and ADPCM enabled.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_jt12_status;

  logic       clk = 1'b0;
  logic       rst, cen, write, addr0;
  logic       timer_ovf_A, timer_ovf_B, flag_en_A, flag_en_B;
  logic       clr_flag_A, clr_flag_B;
  logic [5:0] adpcma_end, adpcma_mask;
  logic       adpcmb_end, adpcmb_mask;
  logic       busy, flag_A, flag_B, adpcmb_flag, irq_n;
  logic [5:0] adpcma_flags;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  jt12_status #(
    .BUSY_CYCLES(4),
    .use_adpcm  (1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cen         (cen),
    .write       (write),
    .addr0       (addr0),
    .timer_ovf_A (timer_ovf_A),
    .timer_ovf_B (timer_ovf_B),
    .flag_en_A   (flag_en_A),
    .flag_en_B   (flag_en_B),
    .clr_flag_A  (clr_flag_A),
    .clr_flag_B  (clr_flag_B),
    .adpcma_end  (adpcma_end),
    .adpcmb_end  (adpcmb_end),
    .adpcma_mask (adpcma_mask),
    .adpcmb_mask (adpcmb_mask),
    .busy        (busy),
    .flag_A      (flag_A),
    .flag_B      (flag_B),
    .adpcma_flags(adpcma_flags),
    .adpcmb_flag (adpcmb_flag),
    .irq_n       (irq_n)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_pulses();
    write       = 1'b0;
    addr0       = 1'b0;
    timer_ovf_A = 1'b0;
    timer_ovf_B = 1'b0;
    clr_flag_A  = 1'b0;
    clr_flag_B  = 1'b0;
    adpcma_end  = 6'h00;
    adpcmb_end  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cen = 1'b1;
    flag_en_A = 1'b0;
    flag_en_B = 1'b0;
    adpcma_mask = 6'h00;
    adpcmb_mask = 1'b0;
    clear_pulses();
    tick();
    tick();
    rst = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (flag_A !== 1'b0 || flag_B !== 1'b0) begin errors++; $display("FAIL reset_flags: got A=%b B=%b expected 0 0", flag_A, flag_B); end
    checks++; if (adpcma_flags !== 6'h00 || adpcmb_flag !== 1'b0) begin errors++; $display("FAIL reset_adpcm: got %h/%b expected 00/0", adpcma_flags, adpcmb_flag); end
    checks++; if (irq_n !== 1'b1) begin errors++; $display("FAIL reset_irq_n: got %b expected 1", irq_n); end
  endtask

  // Data write at cycle 0 -> busy for cycles 1..4, low from cycle 5.
  task automatic test_busy_timing();
    logic exp;
    cen = 1'b1;
    write = 1'b1; addr0 = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      tick();
      clear_pulses();
      exp = (c <= 4);
      checks++; if (busy !== exp) begin errors++; $display("FAIL busy_timing c%0d: got %b expected %b", c, busy, exp); end
    end
  endtask

  // Data writes at cycles 0 and 3, address write at 2 -> busy through 7.
  task automatic test_reload();
    logic exp;
    cen = 1'b1;
    for (int c = 0; c <= 8; c++) begin
      clear_pulses();
      if (c == 0 || c == 3) begin write = 1'b1; addr0 = 1'b1; end
      if (c == 2)           begin write = 1'b1; addr0 = 1'b0; end
      tick();
      exp = ((c + 1) <= 7);
      checks++; if (busy !== exp) begin errors++; $display("FAIL reload c%0d: got %b expected %b", c + 1, busy, exp); end
    end
    clear_pulses();
  endtask

  // With cen low the count holds; four enabled cycles then empty it.
  task automatic test_cen_hold();
    cen = 1'b0;
    write = 1'b1; addr0 = 1'b1;
    tick();
    clear_pulses();
    for (int c = 0; c < 6; c++) tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL cen_hold: got %b expected 1", busy); end
    cen = 1'b1;
    tick(); tick(); tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL cen_count_3: got %b expected 1", busy); end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cen_count_4: got %b expected 0", busy); end
  endtask

  task automatic test_flag_race();
    flag_en_A = 1'b1;
    timer_ovf_A = 1'b1; clr_flag_A = 1'b1;
    tick();
    clear_pulses();
    checks++; if (flag_A !== 1'b1) begin errors++; $display("FAIL race_set_wins: got %b expected 1", flag_A); end
    clr_flag_A = 1'b1;
    tick();
    clear_pulses();
    checks++; if (flag_A !== 1'b0) begin errors++; $display("FAIL clr_A: got %b expected 0", flag_A); end
    flag_en_B = 1'b0;
    timer_ovf_B = 1'b1;
    tick();
    clear_pulses();
    checks++; if (flag_B !== 1'b0) begin errors++; $display("FAIL en_B_low: got %b expected 0", flag_B); end
    flag_en_B = 1'b1;
    timer_ovf_B = 1'b1;
    tick();
    clear_pulses();
    checks++; if (flag_B !== 1'b1) begin errors++; $display("FAIL set_B: got %b expected 1", flag_B); end
    flag_en_B = 1'b0;
    tick();
    checks++; if (flag_B !== 1'b1) begin errors++; $display("FAIL en_drop_holds_B: got %b expected 1", flag_B); end
    clr_flag_B = 1'b1;
    tick();
    clear_pulses();
    checks++; if (flag_B !== 1'b0) begin errors++; $display("FAIL clr_B: got %b expected 0", flag_B); end
    tick();
    tick();
  endtask

  // Overflow at cycle 0, clear at cycle 5.
  task automatic test_irq_latency();
    logic exp_flag, exp_irq;
    flag_en_A = 1'b1;
    checks++; if (irq_n !== 1'b1) begin errors++; $display("FAIL irq_idle: got %b expected 1", irq_n); end
    for (int c = 0; c <= 7; c++) begin
      clear_pulses();
      if (c == 0) timer_ovf_A = 1'b1;
      if (c == 5) clr_flag_A = 1'b1;
      tick();
      exp_flag = ((c + 1) >= 1 && (c + 1) <= 5);
      exp_irq  = !((c + 1) >= 2 && (c + 1) <= 6);
      checks++; if (flag_A !== exp_flag) begin errors++; $display("FAIL irq_flagA c%0d: got %b expected %b", c + 1, flag_A, exp_flag); end
      checks++; if (irq_n !== exp_irq) begin errors++; $display("FAIL irq_n c%0d: got %b expected %b", c + 1, irq_n, exp_irq); end
    end
    clear_pulses();
  endtask

  task automatic test_adpcm_mask();
    adpcma_end = 6'h21;
    tick();
    clear_pulses();
    checks++; if (adpcma_flags !== 6'h21) begin errors++; $display("FAIL adpcma_set: got %h expected 21", adpcma_flags); end
    tick();
    checks++; if (irq_n !== 1'b0) begin errors++; $display("FAIL adpcma_irq: got %b expected 0", irq_n); end
    adpcma_mask = 6'h01;
    tick();
    checks++; if (adpcma_flags !== 6'h20) begin errors++; $display("FAIL adpcma_mask01: got %h expected 20", adpcma_flags); end
    adpcma_mask = 6'h03;
    adpcma_end  = 6'h02;
    tick();
    clear_pulses();
    checks++; if (adpcma_flags !== 6'h20) begin errors++; $display("FAIL adpcma_mask_wins: got %h expected 20", adpcma_flags); end
    adpcmb_mask = 1'b1; adpcmb_end = 1'b1;
    tick();
    clear_pulses();
    checks++; if (adpcmb_flag !== 1'b0) begin errors++; $display("FAIL adpcmb_masked: got %b expected 0", adpcmb_flag); end
    adpcmb_mask = 1'b0; adpcmb_end = 1'b1;
    tick();
    clear_pulses();
    checks++; if (adpcmb_flag !== 1'b1) begin errors++; $display("FAIL adpcmb_set: got %b expected 1", adpcmb_flag); end
    adpcma_mask = 6'h3F; adpcmb_mask = 1'b1;
    tick();
    checks++; if (adpcma_flags !== 6'h00 || adpcmb_flag !== 1'b0) begin errors++; $display("FAIL adpcm_mask_clear: got %h/%b expected 00/0", adpcma_flags, adpcmb_flag); end
    adpcma_mask = 6'h00; adpcmb_mask = 1'b0;
    tick();
    checks++; if (irq_n !== 1'b1) begin errors++; $display("FAIL adpcm_irq_release: got %b expected 1", irq_n); end
  endtask

  task automatic test_reset_mid();
    flag_en_A = 1'b1; flag_en_B = 1'b1;
    write = 1'b1; addr0 = 1'b1;
    timer_ovf_A = 1'b1; timer_ovf_B = 1'b1;
    adpcma_end = 6'h3F; adpcmb_end = 1'b1;
    tick();
    clear_pulses();
    tick();
    checks++; if (busy !== 1'b1 || flag_A !== 1'b1 || flag_B !== 1'b1 || adpcma_flags !== 6'h3F || adpcmb_flag !== 1'b1 || irq_n !== 1'b0)
      begin errors++; $display("FAIL pre_reset_state: got busy=%b A=%b B=%b a=%h b=%b irq_n=%b expected 1 1 1 3f 1 0", busy, flag_A, flag_B, adpcma_flags, adpcmb_flag, irq_n); end
    rst = 1'b1;
    write = 1'b1; addr0 = 1'b1;
    timer_ovf_A = 1'b1; timer_ovf_B = 1'b1;
    adpcma_end = 6'h3F; adpcmb_end = 1'b1;
    tick();
    rst = 1'b0;
    clear_pulses();
    checks++; if (busy !== 1'b0 || flag_A !== 1'b0 || flag_B !== 1'b0 || adpcma_flags !== 6'h00 || adpcmb_flag !== 1'b0 || irq_n !== 1'b1)
      begin errors++; $display("FAIL reset_mid: got busy=%b A=%b B=%b a=%h b=%b irq_n=%b expected 0 0 0 00 0 1", busy, flag_A, flag_B, adpcma_flags, adpcmb_flag, irq_n); end
    tick();
    checks++; if (busy !== 1'b0 || irq_n !== 1'b1) begin errors++; $display("FAIL post_reset_idle: got busy=%b irq_n=%b expected 0 1", busy, irq_n); end
    write = 1'b1; addr0 = 1'b1;
    tick();
    clear_pulses();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL post_reset_resume: got %b expected 1", busy); end
  endtask

  initial begin
    test_reset();
    test_busy_timing();
    test_reload();
    test_cen_hold();
    test_flag_race();
    test_irq_latency();
    test_adpcm_mask();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
